wb_pwm_fader: RTL

- Wishbone classic slave driving CHANNELS PWM outputs.
- Each output has a programmable target brightness; the current duty steps toward the target at a programmable rate.
- Replaces the fixed led_r/led_g/led_b outputs of the application top with a register-controlled block.
- pwm_o feeds the RGB current-driver PWM inputs, or any PWM pin.

---
 rtl/wb_pwm_fader_if.sv | 22 ++
 rtl/wb_pwm_fader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/wb_pwm_fader_if.sv
// Wishbone classic bus bundle between a bus master and the wb_pwm_fader register slave.
interface wb_pwm_fader_if #(
  parameter int ADDR_W = 4
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_pwm_fader.sv
// Wishbone classic slave driving CHANNELS PWM outputs whose duty fades toward a programmed target.
// Define WB_PWM_FADER_READBACK_EN to make registers readable; otherwise every read returns 0.
module wb_pwm_fader #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  wb_pwm_fader_if.slave       wb,
  output logic [CHANNELS-1:0] pwm_o
);
  // Counter runs 0..2^WIDTH-2 so that a duty of all-ones stays high for the whole period.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [1:0]          ctrl_q, ctrl_d;
  logic [15:0]         prescale_q, prescale_d;
  logic [15:0]         fade_cnt_q, fade_cnt_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    target_q [CHANNELS];
  logic [WIDTH-1:0]    target_d [CHANNELS];
  logic [WIDTH-1:0]    duty_q [CHANNELS];
  logic [WIDTH-1:0]    duty_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         rdata;

  logic req, wr, en, bypass, period_end, fade_tick;
  logic unused_dat;

  assign req        = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
  assign wr         = req && wb.wb_we_i;
  assign en         = ctrl_q[0];
  assign bypass     = ctrl_q[1];
  assign period_end = en && (cnt_q == CNT_LAST);
  assign fade_tick  = period_end && (bypass || (fade_cnt_q == prescale_q));
  assign unused_dat = ^wb.wb_dat_i[31:16];

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    target_d   = target_q;
    duty_d     = duty_q;
    pwm_d      = '0;
    cnt_d      = (!en || period_end) ? '0 : cnt_q + 1'b1;

    if (!en)
      fade_cnt_d = '0;
    else if (period_end)
      fade_cnt_d = fade_tick ? 16'd0 : fade_cnt_q + 16'd1;
    else
      fade_cnt_d = fade_cnt_q;

    // Duty only moves on the period-end cycle and always uses the pre-write target.
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (fade_tick) begin
        if (bypass)
          duty_d[ch] = target_q[ch];
        else if (duty_q[ch] < target_q[ch])
          duty_d[ch] = duty_q[ch] + 1'b1;
        else if (duty_q[ch] > target_q[ch])
          duty_d[ch] = duty_q[ch] - 1'b1;
      end
      pwm_d[ch] = en && (cnt_q < duty_q[ch]);
    end

    if (wr) begin
      if (wb.wb_adr_i == ADDR_W'(0))
        ctrl_d = wb.wb_dat_i[1:0];
      if (wb.wb_adr_i == ADDR_W'(1)) begin
        prescale_d = wb.wb_dat_i[15:0];
        fade_cnt_d = '0;
      end
      for (int ch = 0; ch < CHANNELS; ch++)
        if (wb.wb_adr_i == ADDR_W'(2 + ch))
          target_d[ch] = wb.wb_dat_i[WIDTH-1:0];
    end
  end

  always_comb begin
    rdata = '0;
`ifdef WB_PWM_FADER_READBACK_EN
    if (wb.wb_adr_i == ADDR_W'(0))
      rdata = {30'd0, ctrl_q};
    if (wb.wb_adr_i == ADDR_W'(1))
      rdata = {16'd0, prescale_q};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (wb.wb_adr_i == ADDR_W'(2 + ch))
        rdata = 32'(target_q[ch]);
      if (wb.wb_adr_i == ADDR_W'(2 + CHANNELS + ch))
        rdata = 32'(duty_q[ch]);
    end
`endif
  end

  always_comb begin
    ack_d = req;
    dat_d = (req && !wb.wb_we_i) ? rdata : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      fade_cnt_q <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        target_q[ch] <= '0;
        duty_q[ch]   <= '0;
      end
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      fade_cnt_q <= fade_cnt_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      target_q   <= target_d;
      duty_q     <= duty_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign pwm_o       = pwm_q;
endmodule
